// File: rtl/ramen_ledger_if.sv
// Order/day-close inputs and the weekly report stream of the ramen ledger.
// The master side drives strobes and rep_ready; the slave side is the ledger.
interface ramen_ledger_if;
    logic        order_valid;
    logic        order_success;
    logic        tot_valid;
    logic [27:0] sold_num;
    logic [14:0] total_gain;
    logic        rep_valid;
    logic        rep_ready;
    logic [2:0]  rep_tag;
    logic [19:0] rep_data;
    logic [2:0]  day_idx;
    logic        rep_drop;

    modport master (
        output order_valid, order_success, tot_valid, sold_num, total_gain, rep_ready,
        input  rep_valid, rep_tag, rep_data, day_idx, rep_drop
    );

    modport slave (
        input  order_valid, order_success, tot_valid, sold_num, total_gain, rep_ready,
        output rep_valid, rep_tag, rep_data, day_idx, rep_drop
    );
endinterface

// File: rtl/ramen_ledger.sv
// Daily order tally, weekly saturating accumulation and 7-beat report stream.
// state | meaning
// IDLE  | no report pending, rep_valid low
// SEND  | streaming snapshot beats 0..6, beat = current tag
module ramen_ledger #(
    parameter int DAYS_PER_WEEK = 7,
    parameter int GAIN_W        = 20
) (
    input logic           clk,
    input logic           rst,
    ramen_ledger_if.slave lif
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t               state, state_nxt;
    logic [2:0]           beat, beat_nxt;
    logic                 snap_load, drop_set;
    logic [8:0]           acc_cnt, rej_cnt, acc_eff, rej_eff;
    logic                 acc_inc, rej_inc;
    logic [2:0]           day_idx;
    logic [3:0][9:0]      wk_type, snap_type, type_nxt;
    logic [3:0][10:0]     type_sum;
    logic [3:0][6:0]      cnt;
    logic [GAIN_W-1:0]    wk_gain, snap_gain, gain_nxt;
    logic [GAIN_W:0]      gain_sum;
    logic [11:0]          wk_rej, snap_rej, rej_nxt;
    logic [12:0]          rej_sum;
    logic [6:0]           wk_mis, snap_mis, mis_nxt;
    logic [8:0]           sold_sum;
    logic                 day_mismatch, week_close, rep_drop;
    logic [19:0]          rep_data;

    assign acc_inc    = lif.order_valid && lif.order_success;
    assign rej_inc    = lif.order_valid && !lif.order_success;
    assign acc_eff    = (acc_inc && acc_cnt != 9'h1FF) ? acc_cnt + 9'd1 : acc_cnt;
    assign rej_eff    = (rej_inc && rej_cnt != 9'h1FF) ? rej_cnt + 9'd1 : rej_cnt;
    assign week_close = lif.tot_valid && (day_idx == 3'(DAYS_PER_WEEK - 1));

    // Next weekly values including the day being closed this cycle
    always_comb begin
        cnt[0]       = lif.sold_num[27:21];
        cnt[1]       = lif.sold_num[20:14];
        cnt[2]       = lif.sold_num[13:7];
        cnt[3]       = lif.sold_num[6:0];
        sold_sum     = 9'(cnt[0]) + 9'(cnt[1]) + 9'(cnt[2]) + 9'(cnt[3]);
        day_mismatch = (sold_sum != acc_eff);
        for (int i = 0; i < 4; i++) begin
            type_sum[i] = {1'b0, wk_type[i]} + 11'(cnt[i]);
            type_nxt[i] = type_sum[i][10] ? 10'h3FF : type_sum[i][9:0];
        end
        gain_sum = {1'b0, wk_gain} + (GAIN_W + 1)'(lif.total_gain);
        gain_nxt = gain_sum[GAIN_W] ? {GAIN_W{1'b1}} : gain_sum[GAIN_W-1:0];
        rej_sum  = {1'b0, wk_rej} + 13'(rej_eff);
        rej_nxt  = rej_sum[12] ? 12'hFFF : rej_sum[11:0];
        mis_nxt  = wk_mis;
        mis_nxt[day_idx] = day_mismatch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= 3'd0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    // A week close coinciding with the beat-6 accept starts the next report
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        snap_load = 1'b0;
        drop_set  = 1'b0;
        rep_data  = 20'd0;
        case (state)
            IDLE: begin
                if (week_close) begin
                    state_nxt = SEND;
                    beat_nxt  = 3'd0;
                    snap_load = 1'b1;
                end
            end
            SEND: begin
                case (beat)
                    3'd0:    rep_data = 20'(snap_type[0]);
                    3'd1:    rep_data = 20'(snap_type[1]);
                    3'd2:    rep_data = 20'(snap_type[2]);
                    3'd3:    rep_data = 20'(snap_type[3]);
                    3'd4:    rep_data = 20'(snap_gain);
                    3'd5:    rep_data = 20'(snap_rej);
                    3'd6:    rep_data = 20'(snap_mis);
                    default: rep_data = 20'd0;
                endcase
                if (lif.rep_ready && beat == 3'd6) begin
                    state_nxt = week_close ? SEND : IDLE;
                    beat_nxt  = 3'd0;
                    snap_load = week_close;
                end else begin
                    if (lif.rep_ready) beat_nxt = beat + 3'd1;
                    drop_set = week_close;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt   <= '0;
            rej_cnt   <= '0;
            day_idx   <= '0;
            wk_type   <= '0;
            wk_gain   <= '0;
            wk_rej    <= '0;
            wk_mis    <= '0;
            snap_type <= '0;
            snap_gain <= '0;
            snap_rej  <= '0;
            snap_mis  <= '0;
            rep_drop  <= 1'b0;
        end else begin
            rep_drop <= rep_drop | drop_set;
            if (snap_load) begin
                snap_type <= type_nxt;
                snap_gain <= gain_nxt;
                snap_rej  <= rej_nxt;
                snap_mis  <= mis_nxt;
            end
            if (lif.tot_valid) begin
                acc_cnt <= '0;
                rej_cnt <= '0;
                if (week_close) begin
                    day_idx <= '0;
                    wk_type <= '0;
                    wk_gain <= '0;
                    wk_rej  <= '0;
                    wk_mis  <= '0;
                end else begin
                    day_idx <= day_idx + 3'd1;
                    wk_type <= type_nxt;
                    wk_gain <= gain_nxt;
                    wk_rej  <= rej_nxt;
                    wk_mis  <= mis_nxt;
                end
            end else begin
                acc_cnt <= acc_eff;
                rej_cnt <= rej_eff;
            end
        end
    end

    assign lif.rep_valid = (state == SEND);
    assign lif.rep_tag   = beat;
    assign lif.rep_data  = rep_data;
    assign lif.day_idx   = day_idx;
    assign lif.rep_drop  = rep_drop;
endmodule

// File: tb/tb_ramen_ledger.sv
// Bench for ramen_ledger: three instances (1-day, 7-day, 7-day with 17-bit gain)
// share one stimulus; expected report beats are queued per instance and popped on output.
module tb_ramen_ledger;
    logic        clk = 1'b0;
    logic        rst;
    logic        order_valid, order_success, tot_valid, rep_ready;
    logic [27:0] sold_num;
    logic [14:0] total_gain;

    always #5 clk = ~clk;

    ramen_ledger_if ifa ();
    ramen_ledger_if ifb ();
    ramen_ledger_if ifc ();

    assign ifa.order_valid = order_valid;   assign ifb.order_valid = order_valid;   assign ifc.order_valid = order_valid;
    assign ifa.order_success = order_success; assign ifb.order_success = order_success; assign ifc.order_success = order_success;
    assign ifa.tot_valid = tot_valid;       assign ifb.tot_valid = tot_valid;       assign ifc.tot_valid = tot_valid;
    assign ifa.sold_num = sold_num;         assign ifb.sold_num = sold_num;         assign ifc.sold_num = sold_num;
    assign ifa.total_gain = total_gain;     assign ifb.total_gain = total_gain;     assign ifc.total_gain = total_gain;
    assign ifa.rep_ready = rep_ready;       assign ifb.rep_ready = rep_ready;       assign ifc.rep_ready = rep_ready;

    ramen_ledger #(.DAYS_PER_WEEK(1), .GAIN_W(20)) u_d1  (.clk(clk), .rst(rst), .lif(ifa));
    ramen_ledger #(.DAYS_PER_WEEK(7), .GAIN_W(20)) u_d7  (.clk(clk), .rst(rst), .lif(ifb));
    ramen_ledger #(.DAYS_PER_WEEK(7), .GAIN_W(17)) u_d7g (.clk(clk), .rst(rst), .lif(ifc));

    int checks = 0;
    int errors = 0;
    logic [22:0] qa[$], qb[$], qc[$];
    logic [22:0] exp_a, exp_b;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; order_valid = 1'b0; order_success = 1'b0; tot_valid = 1'b0;
        sold_num = '0; total_gain = '0; rep_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        qa.delete(); qb.delete(); qc.delete();
    endtask

    // Inputs other than the strobes are scrambled when idle; the DUT must ignore them.
    task automatic order(input logic success);
        order_valid = 1'b1; order_success = success;
        tick();
        order_valid = 1'b0; order_success = 1'($urandom);
    endtask

    task automatic day_close(input logic [27:0] s, input logic [14:0] g);
        sold_num = s; total_gain = g; tot_valid = 1'b1;
        tick();
        tot_valid = 1'b0; sold_num = 28'($urandom); total_gain = 15'($urandom);
    endtask

    task automatic push_rep(input int which, input logic [9:0] t0, input logic [9:0] t1,
                            input logic [9:0] t2, input logic [9:0] t3, input logic [19:0] g,
                            input logic [11:0] rj, input logic [6:0] mis);
        logic [19:0] v[7];
        v = '{20'(t0), 20'(t1), 20'(t2), 20'(t3), g, 20'(rj), 20'(mis)};
        for (int i = 0; i < 7; i++) begin
            logic [22:0] e;
            e = {3'(i), v[i]};
            case (which)
                0:       qa.push_back(e);
                1:       qb.push_back(e);
                default: qc.push_back(e);
            endcase
        end
    endtask

    function automatic logic [19:0] sat_add(input logic [19:0] a, input int b, input int w);
        longint s, mx;
        s  = longint'(a) + longint'(b);
        mx = (longint'(1) << w) - 1;
        return (s > mx) ? 20'(mx) : 20'(s);
    endfunction

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({ifa.rep_valid, ifa.rep_tag, ifa.rep_data, ifa.day_idx, ifa.rep_drop} !== 28'd0) begin
            errors++; $display("FAIL reset_d1 got v%b tag%0d data%0d day%0d drop%b exp all 0",
                ifa.rep_valid, ifa.rep_tag, ifa.rep_data, ifa.day_idx, ifa.rep_drop);
        end
        checks++;
        if ({ifb.rep_valid, ifb.rep_tag, ifb.rep_data, ifb.day_idx, ifb.rep_drop} !== 28'd0) begin
            errors++; $display("FAIL reset_d7 got v%b tag%0d data%0d day%0d drop%b exp all 0",
                ifb.rep_valid, ifb.rep_tag, ifb.rep_data, ifb.day_idx, ifb.rep_drop);
        end
        checks++;
        if ({ifc.rep_valid, ifc.rep_tag, ifc.rep_data, ifc.day_idx, ifc.rep_drop} !== 28'd0) begin
            errors++; $display("FAIL reset_d7g got v%b tag%0d data%0d day%0d drop%b exp all 0",
                ifc.rep_valid, ifc.rep_tag, ifc.rep_data, ifc.day_idx, ifc.rep_drop);
        end
    endtask

    task automatic test_single_day();
        do_reset();
        order(1'b0); order(1'b1); order(1'b1); order(1'b1);
        day_close({7'd1, 7'd2, 7'd0, 7'd0}, 15'd700);
        push_rep(0, 1, 2, 0, 0, 700, 1, 0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            exp_a = (qa.size() > 0) ? qa.pop_front() : '1;
            checks++;
            if ({ifa.rep_valid, ifa.rep_tag, ifa.rep_data} !== {1'b1, exp_a}) begin
                errors++; $display("FAIL single_beat%0d got v%b tag%0d data%0d exp tag%0d data%0d",
                    k, ifa.rep_valid, ifa.rep_tag, ifa.rep_data, exp_a[22:20], exp_a[19:0]);
            end
        end
        @(negedge clk);
        checks++;
        if (ifa.rep_valid !== 1'b0) begin
            errors++; $display("FAIL single_end got v%b exp 0", ifa.rep_valid);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        order(1'b1); order(1'b1);
        day_close({7'd3, 21'd0}, 15'd5);
        push_rep(0, 3, 0, 0, 0, 5, 0, 7'd1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            exp_a = (qa.size() > 0) ? qa.pop_front() : '1;
            checks++;
            if ({ifa.rep_valid, ifa.rep_tag, ifa.rep_data} !== {1'b1, exp_a}) begin
                errors++; $display("FAIL mismatch_beat%0d got v%b tag%0d data%0d exp tag%0d data%0d",
                    k, ifa.rep_valid, ifa.rep_tag, ifa.rep_data, exp_a[22:20], exp_a[19:0]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [19:0] ga, gc, t0;
        ga = '0; gc = '0; t0 = '0;
        do_reset();
        for (int d = 0; d < 7; d++) begin
            if (d > 0) tick();
            day_close({7'd127, 21'd0}, 15'd32767);
            ga = sat_add(ga, 32767, 20);
            gc = sat_add(gc, 32767, 17);
            t0 = sat_add(t0, 127, 10);
        end
        push_rep(1, t0[9:0], 0, 0, 0, ga, 0, 7'h7F);
        push_rep(2, t0[9:0], 0, 0, 0, gc, 0, 7'h7F);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            exp_a = (qb.size() > 0) ? qb.pop_front() : '1;
            exp_b = (qc.size() > 0) ? qc.pop_front() : '1;
            checks++;
            if ({ifb.rep_valid, ifb.rep_tag, ifb.rep_data} !== {1'b1, exp_a}) begin
                errors++; $display("FAIL sat20_beat%0d got v%b tag%0d data%0d exp tag%0d data%0d",
                    k, ifb.rep_valid, ifb.rep_tag, ifb.rep_data, exp_a[22:20], exp_a[19:0]);
            end
            checks++;
            if ({ifc.rep_valid, ifc.rep_tag, ifc.rep_data} !== {1'b1, exp_b}) begin
                errors++; $display("FAIL sat17_beat%0d got v%b tag%0d data%0d exp tag%0d data%0d",
                    k, ifc.rep_valid, ifc.rep_tag, ifc.rep_data, exp_b[22:20], exp_b[19:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        order(1'b1); order(1'b0); order(1'b0);
        day_close({7'd0, 7'd0, 7'd1, 7'd0}, 15'd1234);
        push_rep(0, 0, 0, 1, 0, 1234, 2, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            exp_a = (qa.size() > 0) ? qa.pop_front() : '1;
            checks++;
            if ({ifa.rep_valid, ifa.rep_tag, ifa.rep_data} !== {1'b1, exp_a}) begin
                errors++; $display("FAIL bp_beat%0d got v%b tag%0d data%0d exp tag%0d data%0d",
                    k, ifa.rep_valid, ifa.rep_tag, ifa.rep_data, exp_a[22:20], exp_a[19:0]);
            end
        end
        @(posedge clk); #1;
        rep_ready = 1'b0;
        exp_a = (qa.size() > 0) ? qa[0] : '1;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            checks++;
            if ({ifa.rep_valid, ifa.rep_tag, ifa.rep_data} !== {1'b1, exp_a}) begin
                errors++; $display("FAIL bp_hold%0d got v%b tag%0d data%0d exp tag%0d data%0d",
                    h, ifa.rep_valid, ifa.rep_tag, ifa.rep_data, exp_a[22:20], exp_a[19:0]);
            end
        end
        rep_ready = 1'b1;
        for (int k = 2; k < 7; k++) begin
            if (k > 2) @(negedge clk);
            exp_a = (qa.size() > 0) ? qa.pop_front() : '1;
            checks++;
            if ({ifa.rep_valid, ifa.rep_tag, ifa.rep_data} !== {1'b1, exp_a}) begin
                errors++; $display("FAIL bp_beat%0d got v%b tag%0d data%0d exp tag%0d data%0d",
                    k, ifa.rep_valid, ifa.rep_tag, ifa.rep_data, exp_a[22:20], exp_a[19:0]);
            end
        end
        @(negedge clk);
        checks++;
        if (ifa.rep_valid !== 1'b0) begin
            errors++; $display("FAIL bp_end got v%b exp 0", ifa.rep_valid);
        end
    endtask

    task automatic test_drop();
        logic seen;
        do_reset();
        rep_ready = 1'b0;
        day_close(28'd0, 15'd100);
        tick();
        @(negedge clk);
        checks++;
        if ({ifa.rep_drop, ifa.rep_valid} !== 2'b01) begin
            errors++; $display("FAIL drop_first got drop%b v%b exp drop0 v1", ifa.rep_drop, ifa.rep_valid);
        end
        @(posedge clk); #1;
        day_close(28'd0, 15'd200);
        @(negedge clk);
        checks++;
        if ({ifa.rep_drop, ifa.rep_valid, ifa.rep_tag} !== 5'b11000) begin
            errors++; $display("FAIL drop_set got drop%b v%b tag%0d exp drop1 v1 tag0",
                ifa.rep_drop, ifa.rep_valid, ifa.rep_tag);
        end
        push_rep(0, 0, 0, 0, 0, 100, 0, 0);
        rep_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            exp_a = (qa.size() > 0) ? qa.pop_front() : '1;
            checks++;
            if ({ifa.rep_valid, ifa.rep_tag, ifa.rep_data} !== {1'b1, exp_a}) begin
                errors++; $display("FAIL drop_beat%0d got v%b tag%0d data%0d exp tag%0d data%0d",
                    k, ifa.rep_valid, ifa.rep_tag, ifa.rep_data, exp_a[22:20], exp_a[19:0]);
            end
        end
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ifa.rep_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || ifa.rep_drop !== 1'b1) begin
            errors++; $display("FAIL drop_after got second_report=%b drop%b exp 0 and drop1", seen, ifa.rep_drop);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        day_close(28'd0, 15'd10);
        push_rep(0, 0, 0, 0, 0, 10, 0, 0);
        push_rep(0, 0, 0, 0, 0, 20, 0, 0);
        for (int k = 0; k < 14; k++) begin
            if (k == 6) begin
                sold_num = 28'd0; total_gain = 15'd20; tot_valid = 1'b1;
            end else begin
                tot_valid = 1'b0;
            end
            @(negedge clk);
            exp_a = (qa.size() > 0) ? qa.pop_front() : '1;
            checks++;
            if ({ifa.rep_valid, ifa.rep_tag, ifa.rep_data} !== {1'b1, exp_a}) begin
                errors++; $display("FAIL b2b_beat%0d got v%b tag%0d data%0d exp tag%0d data%0d",
                    k, ifa.rep_valid, ifa.rep_tag, ifa.rep_data, exp_a[22:20], exp_a[19:0]);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if ({ifa.rep_valid, ifa.rep_drop} !== 2'b00) begin
            errors++; $display("FAIL b2b_end got v%b drop%b exp v0 drop0", ifa.rep_valid, ifa.rep_drop);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        // day 0: accepted order coincides with the close that reports it
        order_valid = 1'b1; order_success = 1'b1;
        sold_num = {7'd0, 7'd1, 7'd0, 7'd0}; total_gain = 15'd1; tot_valid = 1'b1;
        tick();
        order_valid = 1'b0; tot_valid = 1'b0; order_success = 1'b1;
        tick();
        day_close(28'd0, 15'd1);
        order(1'b1);
        day_close(28'd1, 15'd1);
        day_close(28'd2, 15'd1);
        @(negedge clk);
        checks++;
        if (ifb.day_idx !== 3'd4) begin
            errors++; $display("FAIL same_day_idx got %0d exp 4", ifb.day_idx);
        end
        @(posedge clk); #1;
        order_valid = 1'b1; order_success = 1'b0;
        sold_num = 28'd0; total_gain = 15'd1; tot_valid = 1'b1;
        tick();
        order_valid = 1'b0; tot_valid = 1'b0;
        day_close(28'd0, 15'd1);
        day_close(28'd0, 15'd1);
        push_rep(1, 0, 1, 0, 3, 7, 1, 7'h08);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            exp_a = (qb.size() > 0) ? qb.pop_front() : '1;
            checks++;
            if ({ifb.rep_valid, ifb.rep_tag, ifb.rep_data} !== {1'b1, exp_a}) begin
                errors++; $display("FAIL same_beat%0d got v%b tag%0d data%0d exp tag%0d data%0d",
                    k, ifb.rep_valid, ifb.rep_tag, ifb.rep_data, exp_a[22:20], exp_a[19:0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        day_close(28'd0, 15'd50);
        tick(); tick(); tick();
        @(negedge clk);
        checks++;
        if ({ifa.rep_valid, ifa.rep_tag} !== 4'b1011) begin
            errors++; $display("FAIL midrst_pre got v%b tag%0d exp v1 tag3", ifa.rep_valid, ifa.rep_tag);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifa.rep_valid, ifa.rep_tag, ifa.rep_data, ifa.day_idx, ifa.rep_drop} !== 28'd0) begin
            errors++; $display("FAIL midrst_d1 got v%b tag%0d data%0d day%0d drop%b exp all 0",
                ifa.rep_valid, ifa.rep_tag, ifa.rep_data, ifa.day_idx, ifa.rep_drop);
        end
        checks++;
        if (ifb.day_idx !== 3'd0) begin
            errors++; $display("FAIL midrst_d7_day got %0d exp 0", ifb.day_idx);
        end
    endtask

    initial begin
        test_reset();
        test_single_day();
        test_mismatch();
        test_saturation();
        test_backpressure();
        test_drop();
        test_back_to_back();
        test_same_cycle();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ramen_ledger.md
# ramen_ledger

Downstream bookkeeping stage for the ramen shop core. It consumes the per-order result strobes and the end-of-day totals, then accumulates statistics across a configurable number of business days. It cross-checks each day's reported sold counts against its own tally of accepted orders. At week close it emits a 7-beat report over a valid/ready stream.

## Interface
Parameters:
- DAYS_PER_WEEK, 7: number of day closes per report; legal range 1..7.
- GAIN_W, 20: width of the weekly gain accumulator; legal range 15..20.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- order_valid  in  1  one-cycle strobe, one per processed order.
- order_success  in  1  qualifies order_valid; 1 = order served, 0 = rejected.
- tot_valid  in  1  one-cycle end-of-day strobe.
- sold_num  in  28  day counts packed as [27:21] type0, [20:14] type1, [13:7] type2, [6:0] type3; sampled only with tot_valid.
- total_gain  in  15  day revenue; sampled only with tot_valid.
- rep_valid  out  1  report beat valid.
- rep_ready  in  1  report beat accepted when high together with rep_valid.
- rep_tag  out  3  field id of the current beat.
- rep_data  out  20  beat payload, zero-extended.
- day_idx  out  3  index of the current day within the week, 0..DAYS_PER_WEEK-1.
- rep_drop  out  1  sticky flag; cleared only by rst.

## Operation
- **Daily counters**
  - acc_cnt and rej_cnt are 9 bits each and saturate at 511.
  - order_valid with order_success=1 increments acc_cnt.
  - order_valid with order_success=0 increments rej_cnt.
- **Day close (tot_valid)**
  - Unpack the four 7-bit counts; their sum is 9 bits.
  - day_mismatch = (sum != acc_cnt_effective), where acc_cnt_effective includes any accepted order strobed in the same cycle.
  - Add each type count to wk_type[i]. wk_type[i] is 10 bits and saturates at 1023.
  - Add total_gain to wk_gain (GAIN_W bits, saturating).
  - Add rej_cnt_effective to wk_rej (12 bits, saturating).
  - Set bit day_idx of wk_mis (7 bits) to day_mismatch.
  - Clear acc_cnt and rej_cnt, then increment day_idx.
- **Week close** happens on the tot_valid where day_idx == DAYS_PER_WEEK-1.
  - Copy all weekly accumulators, including this day's contribution, into snapshot registers.
  - Clear the weekly accumulators and set day_idx to 0.
  - If the report FSM is IDLE, it moves to SEND.
  - If the report FSM is still in SEND, the new snapshot is discarded and rep_drop is set. The old report continues unchanged.
- **Report FSM**
  - States: IDLE and SEND. beat is a 3-bit counter.
  - IDLE -> SEND on week close, with beat=0.
  - In SEND, each rep_valid && rep_ready advances beat. The accept of beat 6 returns the FSM to IDLE.
- **Beat contents**
  - tags 0..3 = snapshot wk_type[0..3]
  - tag 4 = wk_gain
  - tag 5 = wk_rej
  - tag 6 = {13'b0, wk_mis}
  - rep_tag always equals beat.
- Order counting and day closes continue normally while in SEND; the FSM only reads snapshot registers.

## Timing
- **Reset values:** rep_valid=0, rep_tag=0, rep_data=0, day_idx=0, rep_drop=0. All counters, accumulators and snapshots are 0; FSM is IDLE.
- **Order latency:** an order strobe at cycle t is reflected in the daily counters at t+1.
- **Simultaneous order and day close:** order_valid and tot_valid in the same cycle count the order into the closing day. The daily counters then restart at 0, not 1.
- **Normal order-to-close spacing:** the upstream core issues tot_valid exactly one cycle after the order's order_valid. That order must be included in the closing day.
- **Report latency:** rep_valid rises at t+1 after the week-closing tot_valid at t. With rep_ready held high, the 7 beats occupy t+1..t+7 and rep_valid is 0 at t+8.
- **Backpressure:** while rep_valid=1 and rep_ready=0, rep_tag and rep_data hold stable. rep_valid never drops before the beat is accepted.
- **Back-to-back weeks:** a week close in the same cycle as the beat-6 accept is not a drop. The FSM re-enters SEND with beat=0 on the new snapshot, so rep_valid stays high.
- **rst mid-report:** the report is aborted and all state returns to reset values on the next edge.
- **Out-of-range strobes:** order_success, sold_num and total_gain are ignored unless their strobe is high.

## Test plan
- **Single day, DAYS_PER_WEEK=1:**
  - Stimulus: 3 accepted orders (types 0,1,1) and 1 rejected; then tot_valid with sold_num={7'd1,7'd2,7'd0,7'd0} and total_gain=700.
  - Required: beats with tags 0..6 = 1, 2, 0, 0, 700, 1, 0, on 7 consecutive cycles with rep_ready=1.
- **Mismatch:**
  - Stimulus: 2 accepted orders, then tot_valid with sold_num reporting 3 sold.
  - Required: tag-6 payload bit0 = 1.
- **Saturation:**
  - Stimulus: 7 days each reporting type0=127 and total_gain=32767, GAIN_W=20.
  - Required: tag0 = 889; tag4 = 229369.
  - Stimulus: repeat with GAIN_W=17.
  - Required: tag4 = 131071.
- **Backpressure:**
  - Stimulus: hold rep_ready=0 for 5 cycles on beat 2, then release.
  - Required: rep_tag=2 and rep_data stay constant for all 5 cycles; the remaining beats follow in order.
- **Drop:**
  - Stimulus: DAYS_PER_WEEK=1, rep_ready=0; issue two day closes (gain 100, then 200).
  - Required: rep_drop=1; after releasing rep_ready, tag4 = 100; no second report follows.
- **Same-cycle strobe and mid-report reset:**
  - Stimulus: order_valid/order_success=1 coincident with a tot_valid reporting 1 sold.
  - Required: no mismatch, and acc_cnt restarts at 0.
  - Stimulus: assert rst during beat 3.
  - Required: rep_valid=0 on the next cycle and all outputs at reset values.
